// File: rtl/ping_pkg.sv
// ping_pkg: shared game-state encoding, default screen geometry and centring helpers
package ping_pkg;
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, HOLD = 2'd2, OVER = 2'd3} game_state_t;
  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int BALL_SIZE_DEF = 8;
  localparam int PAD_W_DEF     = 64;
  function automatic int center(input int extent, input int size);
    return (extent - size) / 2;
  endfunction
  localparam int CENTER_X = center(SCREEN_W_DEF, BALL_SIZE_DEF);
  localparam int CENTER_Y = center(SCREEN_H_DEF, BALL_SIZE_DEF);
endpackage

// File: rtl/ping_game_engine_if.sv
// ping_game_engine_if: frame tick, player controls and drawn positions/scores
interface ping_game_engine_if;
  logic       frame_tick;
  logic       up_left;
  logic       up_right;
  logic       dn_left;
  logic       dn_right;
  logic       serve;
  logic [9:0] ballx;
  logic [8:0] bally;
  logic [9:0] padup;
  logic [9:0] padwn;
  logic [3:0] score_up;
  logic [3:0] score_dn;
  logic [1:0] game_state;
  modport master (
    output frame_tick, up_left, up_right, dn_left, dn_right, serve,
    input  ballx, bally, padup, padwn, score_up, score_dn, game_state
  );
  modport slave (
    input  frame_tick, up_left, up_right, dn_left, dn_right, serve,
    output ballx, bally, padup, padwn, score_up, score_dn, game_state
  );
endinterface

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: per-frame paddle stepping from two buttons, clamped to the screen
module paddle_ctrl #(
  parameter int STEP = 4,
  parameter int MAX  = 576,
  parameter int INIT = 288
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       left,
  input  logic       right,
  output logic [9:0] pos
);
  localparam logic signed [10:0] S = 11'(STEP);
  localparam logic signed [10:0] M = 11'(MAX);
  logic signed [10:0] cur, stp, nxt;
  always_comb begin
    cur = signed'({1'b0, pos});
    stp = (left && !right) ? cur - S : (right && !left) ? cur + S : cur;
    nxt = stp < 11'sd0 ? 11'sd0 : stp > M ? M : stp;
  end
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) pos <= 10'(INIT);
    else if (frame_tick && !freeze) pos <= nxt[9:0];
endmodule

// File: rtl/ping_game_engine.sv
// ping_game_engine: per-frame paddle, ball, bounce, scoring and serve/hold/over sequencing
module ping_game_engine import ping_pkg::*; #(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int BALL_SIZE   = BALL_SIZE_DEF,
  parameter int PAD_W       = PAD_W_DEF,
  parameter int PAD_H       = 8,
  parameter int PAD_TOP_Y   = 16,
  parameter int PAD_BOT_Y   = 456,
  parameter int PAD_STEP    = 4,
  parameter int BALL_STEP   = 2,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9
) (
  input logic               pixel_clock,
  input logic               reset,
  ping_game_engine_if.slave bus
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic signed [10:0] BSTEP    = 11'(BALL_STEP);
  localparam logic signed [10:0] BSZ      = 11'(BALL_SIZE);
  localparam logic signed [10:0] PW       = 11'(PAD_W);
  localparam logic signed [10:0] XMAX     = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] YMAX     = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] TOP_LIM  = 11'(PAD_TOP_Y + PAD_H);
  localparam logic signed [10:0] BOT_Y    = 11'(PAD_BOT_Y);
  localparam logic signed [10:0] BOT_REST = 11'(PAD_BOT_Y - BALL_SIZE);
  localparam logic [9:0] CX = 10'(center(SCREEN_W, BALL_SIZE));
  localparam logic [8:0] CY = 9'(center(SCREEN_H, BALL_SIZE));
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  game_state_t        state, state_n;
  logic [9:0]         ballx, ballx_n, padup, padwn;
  logic [8:0]         bally, bally_n;
  logic               dx, dx_n, dy, dy_n;
  logic [3:0]         score_up, su_n, score_dn, sd_n;
  logic [HW-1:0]      hold_cnt, hold_n;
  logic signed [10:0] bx, by, pu, pd, nx, ny;
  logic               hit_up, hit_dn;

  paddle_ctrl #(.STEP(PAD_STEP), .MAX(SCREEN_W - PAD_W), .INIT(center(SCREEN_W, PAD_W))) u_pad_up (
    .pixel_clock(pixel_clock), .reset(reset), .frame_tick(bus.frame_tick), .freeze(state == OVER),
    .left(bus.up_left), .right(bus.up_right), .pos(padup)
  );

  paddle_ctrl #(.STEP(PAD_STEP), .MAX(SCREEN_W - PAD_W), .INIT(center(SCREEN_W, PAD_W))) u_pad_dn (
    .pixel_clock(pixel_clock), .reset(reset), .frame_tick(bus.frame_tick), .freeze(state == OVER),
    .left(bus.dn_left), .right(bus.dn_right), .pos(padwn)
  );

  // Collision tests use the paddle positions from before this tick's paddle update
  always_comb begin
    bx      = signed'({1'b0, ballx});
    by      = signed'({2'b0, bally});
    pu      = signed'({1'b0, padup});
    pd      = signed'({1'b0, padwn});
    nx      = dx ? bx - BSTEP : bx + BSTEP;
    ny      = dy ? by - BSTEP : by + BSTEP;
    hit_up  = ny <= TOP_LIM && by >= TOP_LIM && bx + BSZ > pu && bx < pu + PW;
    hit_dn  = ny + BSZ >= BOT_Y && by + BSZ <= BOT_Y && bx + BSZ > pd && bx < pd + PW;
    state_n = state;
    ballx_n = ballx;
    bally_n = bally;
    dx_n    = dx;
    dy_n    = dy;
    su_n    = score_up;
    sd_n    = score_dn;
    hold_n  = hold_cnt;
    case (state)
      SERVE: begin
        ballx_n = CX;
        bally_n = CY;
        state_n = bus.serve ? PLAY : SERVE;
      end
      PLAY: begin
        ballx_n = nx < 11'sd0 ? 10'd0 : nx > XMAX ? XMAX[9:0] : nx[9:0];
        dx_n    = (nx < 11'sd0 || nx > XMAX) ? ~dx : dx;
        if (dy) begin
          if (hit_up) begin
            bally_n = TOP_LIM[8:0];
            dy_n    = 1'b0;
          end else if (ny < 11'sd0) begin
            bally_n = 9'd0;
            sd_n    = score_dn + 4'd1;
            state_n = HOLD;
            hold_n  = '0;
            dy_n    = 1'b1;
          end else bally_n = ny[8:0];
        end else begin
          if (hit_dn) begin
            bally_n = BOT_REST[8:0];
            dy_n    = 1'b1;
          end else if (ny > YMAX) begin
            bally_n = YMAX[8:0];
            su_n    = score_up + 4'd1;
            state_n = HOLD;
            hold_n  = '0;
            dy_n    = 1'b0;
          end else bally_n = ny[8:0];
        end
      end
      HOLD: begin
        hold_n = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_n = (score_up == WIN || score_dn == WIN) ? OVER : SERVE;
          ballx_n = (score_up == WIN || score_dn == WIN) ? ballx : CX;
          bally_n = (score_up == WIN || score_dn == WIN) ? bally : CY;
        end
      end
      default: begin
        if (bus.serve) begin
          su_n    = 4'd0;
          sd_n    = 4'd0;
          ballx_n = CX;
          bally_n = CY;
          state_n = SERVE;
        end
      end
    endcase
  end

  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      state    <= SERVE;
      ballx    <= CX;
      bally    <= CY;
      dx       <= 1'b0;
      dy       <= 1'b0;
      score_up <= 4'd0;
      score_dn <= 4'd0;
      hold_cnt <= '0;
    end else if (bus.frame_tick) begin
      state    <= state_n;
      ballx    <= ballx_n;
      bally    <= bally_n;
      dx       <= dx_n;
      dy       <= dy_n;
      score_up <= su_n;
      score_dn <= sd_n;
      hold_cnt <= hold_n;
    end

  assign bus.ballx      = ballx;
  assign bus.bally      = bally;
  assign bus.padup      = padup;
  assign bus.padwn      = padwn;
  assign bus.score_up   = score_up;
  assign bus.score_dn   = score_dn;
  assign bus.game_state = state;
endmodule

// File: doc/ping_game_engine.md
# ping_game_engine

Game-logic stage that sits directly upstream of the VGA top level and produces the `ballx`, `bally`, `padup` and `padwn` positions that the colour generator draws. Once per video frame it:
- moves the two paddles from player buttons;
- advances the ball and resolves wall and paddle bounces;
- detects points and keeps scores;
- sequences serve, point-hold and game-over through a small state machine.

All outputs are registered and change only on a frame tick.

## Interface
Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in lines
- BALL_SIZE, 8, ball edge length (square)
- PAD_W, 64, paddle width
- PAD_H, 8, paddle thickness
- PAD_TOP_Y, 16, top edge of upper paddle
- PAD_BOT_Y, 456, top edge of lower paddle
- PAD_STEP, 4, paddle pixels per frame
- BALL_STEP, 2, ball pixels per frame per axis
- HOLD_FRAMES, 60, frames the ball is frozen after a point
- WIN_SCORE, 9, score that ends the game

Ports:
- pixel_clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame, issued at start of vertical blank
- up_left, up_right  in  1 each  upper-paddle buttons (level)
- dn_left, dn_right  in  1 each  lower-paddle buttons (level)
- serve  in  1  serve/restart request (level, sampled on frame_tick)
- ballx  out  10  ball left edge
- bally  out  9  ball top edge
- padup  out  10  upper-paddle left edge
- padwn  out  10  lower-paddle left edge
- score_up, score_dn  out  4 each  points per player
- game_state  out  2  SERVE=0, PLAY=1, HOLD=2, OVER=3

## Operation
- Reset values:
  - ballx=316, bally=236 (centre position);
  - padup=padwn=288;
  - scores 0, game_state SERVE, hold counter 0;
  - dx=0 (right), dy=0 (down).
- Nothing changes on cycles without frame_tick.
- Paddles (every state except OVER):
  - left-only: subtract PAD_STEP;
  - right-only: add PAD_STEP;
  - both or neither: hold.
  - Clamp to [0, SCREEN_W-PAD_W].
- SERVE:
  - Ball held at the centre position.
  - serve=1 on a tick → PLAY; the ball keeps its current dx/dy.
- PLAY, horizontal:
  - nx = ballx ± BALL_STEP.
  - nx<0 → 0 and toggle dx; nx>SCREEN_W-BALL_SIZE → SCREEN_W-BALL_SIZE and toggle dx.
- PLAY, vertical, moving up (dy=1):
  - ny = bally − BALL_STEP.
  - Bounce when ny ≤ PAD_TOP_Y+PAD_H, bally ≥ PAD_TOP_Y+PAD_H, and the ball overlaps the upper paddle (ballx+BALL_SIZE > padup and ballx < padup+PAD_W). Result: bally=PAD_TOP_Y+PAD_H and dy=0.
  - Otherwise, if ny<0: lower player scores, bally=0.
- PLAY, vertical, moving down: mirror case.
  - Bounce when ny+BALL_SIZE ≥ PAD_BOT_Y and the ball overlaps padwn. Result: bally=PAD_BOT_Y−BALL_SIZE and dy=1.
  - ny > SCREEN_H−BALL_SIZE: upper player scores, bally=SCREEN_H−BALL_SIZE.
- Which paddle position is used: collision uses the pre-tick padup/padwn, not the values updated on the same tick.
- Arithmetic: all intermediates are 11-bit signed so edge underflow is detectable.
- Score: the scorer increments → HOLD with hold counter cleared. dy is set to serve toward the player who conceded.
- HOLD:
  - Ball frozen; counter increments per tick.
  - At HOLD_FRAMES−1: if either score == WIN_SCORE → OVER; else → SERVE with the ball recentred.
- OVER:
  - Paddles and ball frozen.
  - serve=1 on a tick → scores cleared, ball centred, → SERVE.
- Both axes are handled independently: a corner hit toggles dx and resolves y in the same tick.

## Timing
- Latency: exactly one pixel_clock after the frame_tick cycle, all registered outputs update together. They are stable for the rest of the frame, i.e. throughout active video.
- Assertion of reset at any time immediately forces all reset values. The first tick after release behaves as a SERVE-state tick.
- frame_tick on consecutive cycles is legal; each tick is a full update.
- serve is ignored in PLAY and HOLD.

## Structure
- Shared package `ping_pkg`:
  - the game_state enum;
  - default screen geometry constants;
  - centre-position constants, derived from SCREEN_W/SCREEN_H/BALL_SIZE.
- Sub-module `paddle_ctrl`:
  - ports: pixel_clock, reset, frame_tick, freeze, left, right, pos;
  - instantiated twice, for the upper and lower paddle.
- Ball motion, collision and the FSM live in the top module.

## Test plan
- Reset mid-PLAY → next cycle ballx=316, bally=236, padup=padwn=288, scores 0, game_state=0.
- padup=0, up_left held 3 ticks → stays 0. up_right held 200 ticks → saturates at 576. up_left+up_right together → unchanged.
- PLAY, ballx=631, dx=0, tick → ballx=632 with dx toggled. Next tick → ballx=630.
- Ball moving up, bally=25, ballx=300, padup=288, tick → bally=24, dy=0. Repeat with padup=0 → ball continues, reaches 0, score_dn=1, game_state=2.
- HOLD entered → exactly 60 ticks later game_state=0 with the ball centred. Ticks without serve → remains SERVE.
- score_dn=8, lower player scores → score_dn=9, after HOLD game_state=3. Paddle buttons → no motion. serve on tick → scores 0, state SERVE.
